// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: eight-digit multiplexed 7-segment scan controller.
// Each digit owns a slot of SCAN_DIV cycles. The first DEAD_CYCLES of the
// slot keep every anode off, and the rest of the slot drives the digit.
// Inputs are shadowed once per frame so a frame never mixes old and new
// values.
// Optional blink support is enabled with `define DISPLAY_SCAN_BLINK_EN.
module display_scan_ctrl #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEAD_CYCLES  = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] digits,
  input  logic [7:0]  blank_mask,
  input  logic [7:0]  blink_mask,
  output logic [6:0]  seg,
  output logic [7:0]  an,
  output logic        frame_start
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);

  typedef enum logic {DEAD, DRIVE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   digits_sh;
  logic [7:0]    blank_sh;
  logic          frame_top;   // cnt=0, idx=0: first cycle of a frame
  logic          frame_end;   // last cycle of digit 7's slot
  logic          slot_end;
  logic          suppress;
  logic [3:0]    nib;
  logic [6:0]    dec;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_top = (cnt == '0) && (idx == 3'd0);
  assign frame_end = slot_end && (idx == 3'd7);
  assign nib       = digits_sh[{idx, 2'b00} +: 4];

  // Slot counter and digit index; idx advances on every slot wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 3'd0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Per-slot FSM: DEAD while the anodes settle, then DRIVE until the slot ends.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= DEAD;
    end else begin
      case (state)
        DEAD:    if (cnt == DEAD_LAST) state <= DRIVE;
        DRIVE:   if (slot_end)         state <= DEAD;
        default:                       state <= DEAD;
      endcase
    end
  end

  // Frame-coherent copies of the inputs, taken on the first cycle of a frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digits_sh <= '0;
      blank_sh  <= '0;
    end else if (frame_top) begin
      digits_sh <= digits;
      blank_sh  <= blank_mask;
    end
  end

`ifdef DISPLAY_SCAN_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] bcnt;
  logic          phase;
  logic [7:0]    blink_sh;

  // Frame counter for blinking. It advances as each frame ends, so the new
  // phase is already in place for the frame that frame_start announces.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcnt     <= '0;
      phase    <= 1'b0;
      blink_sh <= '0;
    end else begin
      if (frame_top) blink_sh <= blink_mask;
      if (frame_end) begin
        if (bcnt == BLINK_LAST) begin
          bcnt  <= '0;
          phase <= ~phase;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
    end
  end

  assign suppress = blank_sh[idx] | (phase & blink_sh[idx]);
`else
  // Blink input has no function in this build.
  logic unused_blink;
  assign unused_blink = ^{blink_mask, frame_end};
  assign suppress     = blank_sh[idx];
`endif

  // Active-low BCD decode; non-decimal nibbles stay dark.
  always_comb begin
    dec = 7'h7F;
    case (nib)
      4'd0:    dec = 7'h40;
      4'd1:    dec = 7'h79;
      4'd2:    dec = 7'h24;
      4'd3:    dec = 7'h30;
      4'd4:    dec = 7'h19;
      4'd5:    dec = 7'h12;
      4'd6:    dec = 7'h02;
      4'd7:    dec = 7'h78;
      4'd8:    dec = 7'h00;
      4'd9:    dec = 7'h10;
      default: dec = 7'h7F;
    endcase
  end

  // Registered outputs: one cycle behind cnt/idx, so there are no decode
  // glitches on the pins and at most one anode is ever low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an          <= 8'hFF;
      seg         <= 7'h7F;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_top;
      if (state == DRIVE && !suppress) begin
        an  <= ~(8'h01 << idx);
        seg <= dec;
      end else begin
        an  <= 8'hFF;
        seg <= 7'h7F;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: a frame-position reference model checks every
// cycle, with table vectors and hand-written corner sequences on top.
module tb_display_scan_ctrl;
  localparam int SD    = 64;
  localparam int DC    = 4;
  localparam int BF    = 2;
  localparam int FRAME = 8 * SD;
`ifdef DISPLAY_SCAN_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] digits = '0;
  logic [7:0]  blank_mask = '0;
  logic [7:0]  blink_mask = '0;
  logic [6:0]  seg;
  logic [7:0]  an;
  logic        frame_start;

  display_scan_ctrl #(.SCAN_DIV(SD), .DEAD_CYCLES(DC), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .digits(digits), .blank_mask(blank_mask),
    .blink_mask(blink_mask), .seg(seg), .an(an), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int k = 0;        // output index since reset release
  int last_p = -1;  // frame position of the latest output, -1 in reset
  logic [31:0] m_digits = '0;
  logic [7:0]  m_blank = '0;
  logic [7:0]  m_blink = '0;
  logic [6:0]  dec_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

  typedef struct {
    logic [31:0] d;
    logic [7:0]  bl;
    int          slot;
    int          cyc;
    logic [7:0]  ea;
    logic [6:0]  es;
  } vec_t;
  vec_t tab [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: model the output for this edge, then compare on the falling edge.
  task automatic tick();
    logic       r;
    int         p, f, s, c;
    logic [7:0] ea;
    logic [6:0] es;
    logic       ef, sup;
    logic [3:0] nb;
    @(posedge clk);
    r = rst_n;
    ea = 8'hFF; es = 7'h7F; ef = 1'b0;
    if (!r) begin
      k = 0;
      last_p = -1;
    end else begin
      p = k % FRAME; f = k / FRAME; s = p / SD; c = p % SD;
      if (p == 0) begin
        m_digits = digits; m_blank = blank_mask; m_blink = blink_mask;
      end
      sup = m_blank[s] | (BLINK && ((f / BF) % 2 == 1) && m_blink[s]);
      ef  = (p == 0);
      if (c >= DC && !sup) begin
        nb = m_digits[s*4 +: 4];
        ea = ~(8'h01 << s);
        es = dec_tab[nb];
      end
      last_p = p;
      k++;
    end
    @(negedge clk);
    chk("model_an", {24'h0, an}, {24'h0, ea});
    chk("model_seg", {25'h0, seg}, {25'h0, es});
    chk("model_fs", {31'h0, frame_start}, {31'h0, ef});
    chk("an_onehot", {31'h0, ($countones(~an) <= 1)}, 32'h1);
  endtask

  task automatic goto_p(input int target);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (last_p != target && n < 3 * FRAME);
    if (last_p != target) begin
      checks++; failures++;
      $display("FAIL goto_timeout: at %0d expected %0d", last_p, target);
    end
  endtask

  initial begin
    int dead_ok, lit_ok, n, pulses;
    bit lit;

    tab[0]  = '{32'h76543210, 8'h00, 3, 30, 8'hF7, 7'h30};
    tab[1]  = '{32'h76543210, 8'h00, 3,  1, 8'hFF, 7'h7F};
    tab[2]  = '{32'h76543210, 8'h00, 6, 63, 8'hBF, 7'h02};
    tab[3]  = '{32'h00B00000, 8'h00, 5, 10, 8'hDF, 7'h7F};
    tab[4]  = '{32'h76543210, 8'h81, 0, 20, 8'hFF, 7'h7F};
    tab[5]  = '{32'h76543210, 8'h81, 7, 20, 8'hFF, 7'h7F};
    tab[6]  = '{32'h76543210, 8'h81, 1, 20, 8'hFD, 7'h79};
    tab[7]  = '{32'h76543210, 8'h81, 6, 20, 8'hBF, 7'h02};
    tab[8]  = '{32'h89898989, 8'h00, 0, 40, 8'hFE, 7'h10};
    tab[9]  = '{32'h89898989, 8'h00, 1, 40, 8'hFD, 7'h00};
    tab[10] = '{32'h0000F000, 8'h00, 3, 50, 8'hF7, 7'h7F};
    tab[11] = '{32'h76543210, 8'h00, 4,  4, 8'hEF, 7'h19};

    // Reset state, then the first cycle after release.
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_an", {24'h0, an}, 32'hFF);
    chk("rst_seg", {25'h0, seg}, 32'h7F);
    chk("rst_fs", {31'h0, frame_start}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("first_fs", {31'h0, frame_start}, 32'h1);
    chk("first_an", {24'h0, an}, 32'hFF);

    // Table vectors: inputs land at the next frame, checked mid-slot.
    foreach (tab[i]) begin
      digits = tab[i].d; blank_mask = tab[i].bl; blink_mask = 8'h00;
      goto_p(0);
      goto_p(tab[i].slot * SD + tab[i].cyc);
      chk($sformatf("tab%0d_an", i), {24'h0, an}, {24'h0, tab[i].ea});
      chk($sformatf("tab%0d_seg", i), {25'h0, seg}, {25'h0, tab[i].es});
    end

    // Whole slot of digit 3: 4 dark cycles then 60 lit cycles.
    digits = 32'h76543210; blank_mask = 8'h00;
    goto_p(0);
    goto_p(3 * SD - 1);
    dead_ok = 0; lit_ok = 0;
    for (int c = 0; c < SD; c++) begin
      tick();
      if (c < DC && an == 8'hFF && seg == 7'h7F) dead_ok++;
      if (c >= DC && an == 8'hF7 && seg == 7'h30) lit_ok++;
    end
    chk("d3_dead_cycles", dead_ok, DC);
    chk("d3_lit_cycles", lit_ok, SD - DC);

    // Frame period and pulse count, measured on the pins.
    goto_p(0);
    n = 0;
    do begin tick(); n++; end while (frame_start !== 1'b1 && n < 2 * FRAME);
    chk("frame_period", n, FRAME);
    pulses = 0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      tick();
      if (frame_start) pulses++;
    end
    chk("frame_pulses", pulses, 2);

    // Mid-frame change: rest of frame keeps old value, next frame shows new.
    digits = 32'h11111111;
    goto_p(0);
    goto_p(200);
    digits = 32'h22222222;
    for (int s = 4; s < 8; s++) begin
      goto_p(s * SD + 30);
      chk($sformatf("midchg_old%0d", s), {25'h0, seg}, 32'h79);
    end
    for (int s = 0; s < 4; s++) begin
      goto_p(s * SD + 30);
      chk($sformatf("midchg_new%0d", s), {25'h0, seg}, 32'h24);
    end

    // One-cycle reset mid-slot of digit 6.
    goto_p(6 * SD + 20);
    rst_n = 1'b0;
    digits = 32'h76543210; blink_mask = 8'h04;
    tick();
    chk("mrst_an", {24'h0, an}, 32'hFF);
    chk("mrst_fs", {31'h0, frame_start}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("mrst_next_an", {24'h0, an}, 32'hFF);
    chk("mrst_next_seg", {25'h0, seg}, 32'h7F);
    chk("mrst_next_fs", {31'h0, frame_start}, 32'h1);
    repeat (DC - 1) tick();
    chk("mrst_still_dead", {24'h0, an}, 32'hFF);
    tick();
    chk("mrst_d0_an", {24'h0, an}, 32'hFE);
    chk("mrst_d0_seg", {25'h0, seg}, 32'h40);

    // Blink on digit 2 over six frames counted from the reset above.
    for (int fr = 0; fr < 6; fr++) begin
      goto_p(2 * SD + 30);
      lit = !BLINK || ((fr / BF) % 2 == 0);
      chk($sformatf("blink_f%0d_an", fr), {24'h0, an}, lit ? 32'hFB : 32'hFF);
      chk($sformatf("blink_f%0d_seg", fr), {25'h0, seg}, lit ? 32'h24 : 32'h7F);
    end

    // Random input traffic with occasional resets; the model checks every cycle.
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 63) == 0) digits = $urandom;
      if ($urandom_range(0, 127) == 0) blank_mask = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 127) == 0) blink_mask = 8'($urandom);
      rst_n = ($urandom_range(0, 1999) != 0);
      tick();
    end
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
